// File: rtl/vga_pkg.sv
// Shared field positions, default 640x480@60 timing and lock-state encoding
// for the VGA sink.
package vga_pkg;
    localparam int HSYNC_BIT = 13;
    localparam int VSYNC_BIT = 12;
    localparam int RGB_MSB   = 11;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int HCNT_W = 10;
    localparam int VCNT_W = 10;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;
endpackage

// File: rtl/vga_sync_edge.sv
// Two-flop history on an active-low sync line; r_cur is the registered input
// sample, r_prev the one before it. Both idle high (deasserted).
module vga_sync_edge (
    input  logic vga_clk,
    input  logic reset_n,
    input  logic i_sync,
    output logic o_fall,
    output logic o_rise
);
    logic r_cur;
    logic r_prev;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur  <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_cur  <= i_sync;
            r_prev <= r_cur;
        end
    end

    assign o_fall = r_prev & ~r_cur;
    assign o_rise = ~r_prev & r_cur;
endmodule

// File: rtl/vga_rx.sv
// VGA sink: locks onto hsync/vsync, recovers pixel coordinates and colour,
// and counts locked frames and timing errors.
module vga_rx
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic [13:0] vgaData,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [15:0] frame_count,
    output logic [7:0]  err_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [HCNT_W-1:0] HC_LAST  = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] HC_SYNC1 = HCNT_W'(H_SYNC - 1);
    localparam logic [HCNT_W-1:0] HC_ACT0  = HCNT_W'(H_SYNC + H_BP);
    localparam logic [HCNT_W-1:0] HC_ACT1  = HCNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [VCNT_W-1:0] VC_LAST  = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] VC_ACT0  = VCNT_W'(V_SYNC + V_BP);
    localparam logic [VCNT_W-1:0] VC_ACT1  = VCNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);

    logic [11:0]       r_rgb1;
    logic              w_hfall, w_hrise, w_vfall;
    logic [HCNT_W-1:0] r_hcnt, w_hcnt_nxt;
    logic [VCNT_W-1:0] r_vcnt, w_vcnt_nxt;
    logic              r_varm, w_varm_nxt;
    logic              w_err;
    lock_state_t       r_state, w_state_nxt;
    logic              w_locked, w_fc_inc, w_pv_nxt, w_fs_nxt;
    logic              r_pix_valid, r_frame_start;
    logic [9:0]        r_pix_x;
    logic [8:0]        r_pix_y;
    logic [11:0]       r_pix_rgb;
    logic [15:0]       r_frame_count;
    logic [7:0]        r_err_count;

    // Stage 1: input sample (sync history lives in the edge detectors)
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) r_rgb1 <= '0;
        else          r_rgb1 <= vgaData[RGB_MSB:0];
    end

    vga_sync_edge u_hs (.vga_clk(vga_clk), .reset_n(reset_n),
                        .i_sync(vgaData[HSYNC_BIT]), .o_fall(w_hfall), .o_rise(w_hrise));
    vga_sync_edge u_vs (.vga_clk(vga_clk), .reset_n(reset_n),
                        .i_sync(vgaData[VSYNC_BIT]), .o_fall(w_vfall), .o_rise());

    // Counter values assigned to the sample now in stage 1; r_* hold the previous sample's.
    always_comb begin
        w_hcnt_nxt = r_hcnt;
        if (w_hfall)             w_hcnt_nxt = '0;
        else if (r_hcnt != '1)   w_hcnt_nxt = r_hcnt + 1'b1;
        w_vcnt_nxt = r_vcnt;
        w_varm_nxt = r_varm;
        if (w_hfall) begin
            w_varm_nxt = 1'b0;
            if (r_varm || w_vfall)  w_vcnt_nxt = '0;
            else if (r_vcnt != '1)  w_vcnt_nxt = r_vcnt + 1'b1;
        end else if (w_vfall) begin
            w_varm_nxt = 1'b1;
        end
    end

    always_comb begin
        w_err = (r_state != HUNT) &&
                ((w_hfall && (r_hcnt != HC_LAST)) ||
                 (w_hrise && (r_hcnt != HC_SYNC1)) ||
                 (!w_hfall && (r_hcnt == HC_LAST)) ||
                 (w_vfall && (r_vcnt != VC_LAST)));
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) r_state <= HUNT;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HUNT:    if (w_vfall) w_state_nxt = ALIGN;
            ALIGN:   if (w_err) w_state_nxt = HUNT;
                     else if (w_vfall) w_state_nxt = LOCKED;
            LOCKED:  if (w_err) w_state_nxt = HUNT;
            default: w_state_nxt = HUNT;
        endcase
    end

    // Outputs follow the next state so the sample that exposes an error is never emitted.
    always_comb begin
        w_locked = (r_state == LOCKED);
        w_fc_inc = w_vfall && (w_state_nxt == LOCKED);
        w_pv_nxt = (w_state_nxt == LOCKED) &&
                   (w_hcnt_nxt >= HC_ACT0) && (w_hcnt_nxt <= HC_ACT1) &&
                   (w_vcnt_nxt >= VC_ACT0) && (w_vcnt_nxt <= VC_ACT1);
        w_fs_nxt = w_pv_nxt && (w_hcnt_nxt == HC_ACT0) && (w_vcnt_nxt == VC_ACT0);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_varm        <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_rgb     <= '0;
            r_frame_count <= '0;
            r_err_count   <= '0;
        end else begin
            r_hcnt        <= w_hcnt_nxt;
            r_vcnt        <= w_vcnt_nxt;
            r_varm        <= w_varm_nxt;
            r_pix_valid   <= w_pv_nxt;
            r_frame_start <= w_fs_nxt;
            if (w_pv_nxt) begin
                r_pix_x   <= w_hcnt_nxt - HC_ACT0;
                r_pix_y   <= 9'(w_vcnt_nxt - VC_ACT0);
                r_pix_rgb <= r_rgb1;
            end
            if (w_fc_inc) r_frame_count <= r_frame_count + 16'd1;
            if (w_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
        end
    end

    assign pix_valid   = r_pix_valid;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pix_rgb     = r_pix_rgb;
    assign frame_start = r_frame_start;
    assign locked      = w_locked;
    assign frame_count = r_frame_count;
    assign err_count   = r_err_count;
endmodule

// File: tb/tb_vga_rx.sv
// Directed bench for vga_rx on a shrunken raster (34x19 totals) so every
// lock, error and reset scenario fits in a few thousand clocks.
module tb_vga_rx;
    localparam int HA = 16, HF = 4, HS = 8, HB = 6;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [13:0] vgaData = 14'h3FFF;
    logic        pix_valid, frame_start, locked;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [11:0] pix_rgb;
    logic [15:0] frame_count;
    logic [7:0]  err_count;

    vga_rx #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
             .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .vgaData(vgaData),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .locked(locked),
        .frame_count(frame_count), .err_count(err_count));

    always #20 vga_clk = ~vga_clk;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // Running pixel monitor; each emitted pixel must carry its own coordinates in R/G.
    int mon_pix = 0, mon_bad = 0, mon_fs = 0;
    logic [9:0] fs_x = '1;
    logic [8:0] fs_y = '1;
    always @(negedge vga_clk) begin
        if (pix_valid) begin
            mon_pix++;
            if (pix_rgb !== {pix_x[3:0], pix_y[3:0], 4'hA} || pix_x >= HA || pix_y >= VA)
                mon_bad++;
        end
        if (frame_start) begin
            mon_fs++;
            fs_x = pix_x;
            fs_y = pix_y;
        end
    end

    task automatic step(input logic hs, input logic vs, input logic [11:0] rgb);
        vgaData = {hs, vs, rgb};
        @(posedge vga_clk);
        #1;
    endtask

    task automatic seg(input int y, input int hc0, input int hc1, input logic hs_en);
        for (int hc = hc0; hc < hc1; hc++) begin
            int px, py;
            logic [11:0] rgb;
            px = hc - (HS + HB);
            py = y - (VS + VB);
            rgb = (px >= 0 && px < HA && py >= 0 && py < VA) ? {px[3:0], py[3:0], 4'hA} : 12'h0;
            step(!(hs_en && hc < HS), !(y < VS), rgb);
        end
    endtask

    task automatic lines(input int y0, input int y1);
        for (int y = y0; y < y1; y++) seg(y, 0, HT, 1'b1);
    endtask

    int p0, b0, f0;

    initial begin
        repeat (5) begin
            vgaData = 14'($urandom);
            @(posedge vga_clk);
            #1;
        end
        chk("rst_pv", pix_valid, 0);
        chk("rst_x", pix_x, 0);
        chk("rst_y", pix_y, 0);
        chk("rst_rgb", pix_rgb, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_lock", locked, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_err", err_count, 0);

        step(1, 1, 0);
        @(negedge vga_clk) reset_n = 1'b1;
        step(1, 1, 0);
        step(1, 1, 0);

        // frame 1: first vsync fall -> ALIGN only
        lines(0, VT);
        chk("f1_lock", locked, 0);
        // frame 2: qualifying vsync fall; locked rises on the second clock after it is launched
        seg(0, 0, 1, 1'b1);
        chk("lk_pre", locked, 0);
        seg(0, 1, 2, 1'b1);
        chk("lk_rise", locked, 1);
        seg(0, 2, HT, 1'b1);
        lines(1, VT);
        chk("f2_fc", frame_count, 1);

        // frame 3: full locked frame
        p0 = mon_pix; b0 = mon_bad; f0 = mon_fs;
        lines(0, VT);
        chk("f3_pix", mon_pix - p0, HA * VA);
        chk("f3_bad", mon_bad - b0, 0);
        chk("f3_fs", mon_fs - f0, 1);
        chk("f3_fs_x", fs_x, 0);
        chk("f3_fs_y", fs_y, 0);
        chk("f3_fc", frame_count, 2);
        chk("f3_err", err_count, 0);

        // frame 4: line 7 one clock short; error registered on line 8's hsync fall
        lines(0, 7);
        seg(7, 0, HT - 1, 1'b1);
        seg(8, 0, 1, 1'b1);
        chk("short_lk_pre", locked, 1);
        seg(8, 1, 2, 1'b1);
        chk("short_lk", locked, 0);
        chk("short_err", err_count, 1);
        seg(8, 2, HT, 1'b1);
        lines(9, VT);
        chk("f4_fc", frame_count, 3);

        // frames 5/6: relock after two clean vsync falls
        lines(0, VT);
        chk("f5_lock", locked, 0);
        lines(0, VT);
        chk("f6_lock", locked, 1);
        chk("f6_fc", frame_count, 4);

        // frame 7: hsync pulse missing on line 3 -> error when hcnt reaches H_TOTAL
        lines(0, 3);
        seg(3, 0, 1, 1'b0);
        chk("hmiss_lk_pre", locked, 1);
        seg(3, 1, 2, 1'b0);
        chk("hmiss_lk", locked, 0);
        chk("hmiss_err", err_count, 2);
        seg(3, 2, HT, 1'b0);
        lines(4, VT);
        chk("f7_fc", frame_count, 5);

        // frame 8 -> ALIGN, frame 9 -> LOCKED but cut short: vsync falls at line VT-5
        lines(0, VT);
        lines(0, VT - 5);
        chk("f9_fc", frame_count, 6);
        lines(0, VT);
        chk("vbad_err", err_count, 3);
        chk("vbad_fc", frame_count, 6);
        chk("vbad_lock", locked, 0);

        // One error per iteration: vsync fall enters ALIGN, premature hsync fall kicks out.
        repeat (200) begin
            step(1, 1, 0); step(1, 0, 0); step(0, 0, 0); step(1, 1, 0);
        end
        chk("err_203", err_count, 203);
        repeat (60) begin
            step(1, 1, 0); step(1, 0, 0); step(0, 0, 0); step(1, 1, 0);
        end
        chk("err_sat", err_count, 255);

        // relock, then reset mid-frame
        lines(0, VT);
        lines(0, VT);
        chk("relock_fc", frame_count, 7);
        lines(0, 10);
        seg(10, 0, HS + HB + 3, 1'b1);
        chk("pv_pre_rst", pix_valid, 1);
        #5 reset_n = 1'b0;
        #1;
        chk("arst_pv", pix_valid, 0);
        chk("arst_lock", locked, 0);
        chk("arst_fc", frame_count, 0);
        chk("arst_err", err_count, 0);
        chk("arst_x", pix_x, 0);
        @(posedge vga_clk);
        #1;
        seg(10, HS + HB + 4, HT, 1'b1);
        @(negedge vga_clk) reset_n = 1'b1;
        lines(11, VT);
        chk("post_rst_fc", frame_count, 0);
        lines(0, VT);
        chk("post_rst_align", locked, 0);
        lines(0, VT);
        chk("post_rst_lock", locked, 1);
        chk("post_rst_fc1", frame_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
